addsub_mc: RTL and testbench



---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_slice.sv | 12 +
 rtl/addsub_mc.sv | 105 ++++++++++
 tb/tb_addsub_mc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op codes, FSM states and slice-count helper for addsub_mc.
package addsub_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // Returns 0 when WIDTH is not a whole number of slices, flagged by the top.
   function automatic int slice_count(input int width, input int slice);
      return (slice > 0 && width % slice == 0) ? width / slice : 0;
   endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit adder with carry in and carry out.
module addsub_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             cin_i,
   output logic [SLICE-1:0] sum_o,
   output logic             cout_o
);
   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
endmodule

// File: rtl/addsub_mc.sv
// addsub_mc: multi-cycle add/subtract, SLICE bits per cycle, LSB slice first.
// Define ADDSUB_ZERO_FLAG_EN to register the Zero flag at completion.
module addsub_mc
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Overflow,
   output logic             Zero
);
   localparam int N  = slice_count(WIDTH, SLICE);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (N == 0) begin : g_bad_cfg
      $error("addsub_mc: WIDTH must be a non-zero multiple of SLICE");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, work_q, work_d, res_q;
   logic [CW-1:0]    cnt_q;
   logic             op_q, carry_q, done_q, cout_q, ovf_q;
   logic [SLICE-1:0] sum_s;
   logic             carry_s, last;

   addsub_slice #(.SLICE(SLICE)) u_slice (
      .a_i    (a_q[cnt_q*SLICE +: SLICE]),
      .b_i    (b_q[cnt_q*SLICE +: SLICE]),
      .cin_i  (carry_q),
      .sum_o  (sum_s),
      .cout_o (carry_s)
   );

   always_comb begin
      work_d = work_q;
      work_d[cnt_q*SLICE +: SLICE] = sum_s;
      last = cnt_q == CW'(N - 1);
      state_d = (state_q == S_IDLE) ? (start ? S_RUN : S_IDLE) : (last ? S_IDLE : S_RUN);
   end

   // b_q holds B already inverted for subtraction, so one overflow rule covers both ops.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_ADD;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= state_q == S_RUN && last;
         if (state_q == S_IDLE) begin
            if (start) begin
               a_q     <= A;
               b_q     <= (op == OP_SUB) ? ~B : B;
               op_q    <= op;
               carry_q <= op;
               cnt_q   <= '0;
            end
         end else begin
            work_q  <= work_d;
            carry_q <= carry_s;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
               res_q  <= work_d;
               cout_q <= op_q ^ carry_s;
               ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (work_d[WIDTH-1] != a_q[WIDTH-1]);
            end
         end
      end
   end

`ifdef ADDSUB_ZERO_FLAG_EN
   logic zero_q;
   always_ff @(posedge clock or posedge clear) begin
      if (clear) zero_q <= 1'b0;
      else if (state_q == S_RUN && last) zero_q <= work_d == '0;
   end
   assign Zero = zero_q;
`else
   assign Zero = 1'b0;
`endif

   assign busy     = state_q == S_RUN;
   assign done     = done_q;
   assign Result   = res_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;
endmodule

// File: tb/tb_addsub_mc.sv
// tb_addsub_mc: three addsub_mc instances (SLICE 8, 32, 1) on shared inputs, checked against a behavioural model.
module tb_addsub_mc;
`ifdef ADDSUB_ZERO_FLAG_EN
   localparam logic ZEN = 1'b1;
`else
   localparam logic ZEN = 1'b0;
`endif

   logic        clock = 1'b0, clear = 1'b1, start = 1'b0, op = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic        busy_w[3], done_w[3], cout_w[3], ovf_w[3], zero_w[3];
   logic [31:0] res_w[3];

   int total = 0, bad = 0;
   int dcnt[3] = '{0, 0, 0};

   logic        m_busy[3], m_done[3], m_cout[3], m_ovf[3], m_zero[3];
   logic        p_cout[3], p_ovf[3];
   logic [31:0] m_res[3], p_res[3];
   int          m_rem[3];

   always #5 clock = ~clock;

   addsub_mc #(.WIDTH(32), .SLICE(8)) dut0 (
      .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
      .busy(busy_w[0]), .done(done_w[0]), .Result(res_w[0]), .Cout(cout_w[0]),
      .Overflow(ovf_w[0]), .Zero(zero_w[0]));
   addsub_mc #(.WIDTH(32), .SLICE(32)) dut1 (
      .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
      .busy(busy_w[1]), .done(done_w[1]), .Result(res_w[1]), .Cout(cout_w[1]),
      .Overflow(ovf_w[1]), .Zero(zero_w[1]));
   addsub_mc #(.WIDTH(32), .SLICE(1)) dut2 (
      .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
      .busy(busy_w[2]), .done(done_w[2]), .Result(res_w[2]), .Cout(cout_w[2]),
      .Overflow(ovf_w[2]), .Zero(zero_w[2]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 1 : 32;
   endfunction

   // {overflow, carry/borrow, result} from signed/unsigned integer arithmetic
   function automatic logic [33:0] ref_op(input logic o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sr;
      logic [31:0] r;
      logic c;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = o ? sa - sb : sa + sb;
      r  = o ? a - b : a + b;
      c  = o ? (a < b) : ({1'b0, a} + {1'b0, b} > 33'h0_FFFF_FFFF);
      return {(sr > 64'sd2147483647) || (sr < -64'sd2147483648), c, r};
   endfunction

   always @(posedge clock or posedge clear) begin
      for (int k = 0; k < 3; k++) begin
         if (clear) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_res[k] <= '0;
            m_cout[k] <= 1'b0; m_ovf[k] <= 1'b0; m_zero[k] <= 1'b0; m_rem[k] <= 0;
         end else begin
            m_done[k] <= 1'b0;
            if (m_busy[k]) begin
               m_rem[k] <= m_rem[k] - 1;
               if (m_rem[k] == 1) begin
                  m_busy[k] <= 1'b0; m_done[k] <= 1'b1; m_res[k] <= p_res[k];
                  m_cout[k] <= p_cout[k]; m_ovf[k] <= p_ovf[k]; m_zero[k] <= ZEN && p_res[k] == 0;
               end
            end else if (start) begin
               m_busy[k] <= 1'b1;
               m_rem[k]  <= lat_of(k);
               {p_ovf[k], p_cout[k], p_res[k]} <= ref_op(op, A, B);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m_busy[k]));
         chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(m_done[k]));
         chk($sformatf("result%0d", k), res_w[k], m_res[k]);
         chk($sformatf("cout%0d", k), 32'(cout_w[k]), 32'(m_cout[k]));
         chk($sformatf("ovf%0d", k), 32'(ovf_w[k]), 32'(m_ovf[k]));
         chk($sformatf("zero%0d", k), 32'(zero_w[k]), 32'(m_zero[k]));
         if (done_w[k]) dcnt[k] <= dcnt[k] + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input logic eo, input logic ez);
      int lat[3] = '{0, 0, 0};
      op = o; A = a; B = b; start = 1'b1;
      tick();
      start = 1'b0; A = $urandom; B = $urandom;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         for (int k = 0; k < 3; k++) if (done_w[k] && lat[k] == 0) lat[k] = c;
      end
      chk("model_result", m_res[0], er);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("lat%0d", k), lat[k], lat_of(k));
         chk($sformatf("lit_result%0d", k), res_w[k], er);
         chk($sformatf("lit_cout%0d", k), 32'(cout_w[k]), 32'(ec));
         chk($sformatf("lit_ovf%0d", k), 32'(ovf_w[k]), 32'(eo));
         chk($sformatf("lit_zero%0d", k), 32'(zero_w[k]), 32'(ez));
      end
   endtask

   initial begin
      int base[3];
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 0);
         chk($sformatf("rst_result%0d", k), res_w[k], 0);
      end
      tick(); tick();
      clear = 1'b0;
      tick();

      run_op(1'b1, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0);
      run_op(1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, ZEN);
      run_op(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      run_op(1'b1, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, ZEN);

      // starts sampled at e0, e0+2 (ignored by SLICE=8) and e0+5 (its done cycle)
      base[0] = dcnt[0];
      op = 1'b0; A = 32'd10; B = 32'd20; start = 1'b1; tick();
      start = 1'b0; tick();
      op = 1'b1; A = 32'd99; B = 32'd1; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      op = 1'b1; A = 32'd50; B = 32'd8; start = 1'b1; tick();
      start = 1'b0;
      repeat (40) tick();
      chk("b2b_dones0", dcnt[0] - base[0], 2);
      chk("b2b_result0", res_w[0], 32'd42);

      // clear two cycles into a run
      for (int k = 0; k < 3; k++) base[k] = dcnt[k];
      op = 1'b0; A = 32'd1; B = 32'd2; start = 1'b1; tick();
      start = 1'b0; tick();
      clear = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("clr_busy%0d", k), 32'(busy_w[k]), 0);
         chk($sformatf("clr_result%0d", k), res_w[k], 0);
         chk($sformatf("clr_flags%0d", k), {29'd0, cout_w[k], ovf_w[k], zero_w[k]}, 0);
      end
      tick();
      clear = 1'b0;
      repeat (40) tick();
      for (int k = 0; k < 3; k++) chk($sformatf("clr_nodone%0d", k), dcnt[k] - base[k], 0);
      run_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         start = ($urandom % 3) == 0;
         op = $urandom;
         A = ($urandom % 6 == 0) ? 32'h8000_0000 : $urandom;
         B = ($urandom % 8 == 0) ? A : $urandom;
         clear = ($urandom % 97) == 0;
         tick();
      end
      clear = 1'b0; start = 1'b0;
      repeat (40) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end
endmodule
